pipeline_ctrl: RTL and testbench

Sequencing controller for the five-stage RISC-V pipeline. It drives the load and flush controls of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, which are all built from n-bit load-enabled registers. It resolves three conditions in a fixed priority order:
- multi-cycle data-memory stalls,
- taken-branch flushes,
- load-use hazards.

It also holds the halted state and a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_ctrl_pkg.sv | 12 +
 rtl/pipeline_ctrl_hazard_detect.sv | 22 ++
 rtl/pipeline_ctrl.sv | 113 +++++++++++
 tb/tb_pipeline_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

   localparam int REG_ADDR_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection: an EX load whose destination is read by the ID
// instruction. x0 never creates a dependency.
module pipeline_ctrl_hazard_detect #(
   parameter int REG_ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W_DEF
) (
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  load_use
);

   // Compare both source specifiers against the load destination
   always_comb begin
      load_use = ex_mem_read && (ex_rd != '0) &&
                 ((id_rs1_used && (id_rs1 == ex_rd)) ||
                  (id_rs2_used && (id_rs2 == ex_rd)));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencing controller: freeze on memory wait, flush on
// taken branch, bubble on load-use, plus halt state and stall counter.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   input  logic                  wb_halt,
   output logic                  pc_load,
   output logic                  ifid_load,
   output logic                  idex_load,
   output logic                  exmem_load,
   output logic                  memwb_load,
   output logic                  ifid_flush,
   output logic                  idex_flush,
   output logic                  halted,
   output logic [CNT_W-1:0]      stall_cnt
);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic             load_use;
   logic             mem_stall;

   pipeline_ctrl_hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   assign mem_stall = mem_req && !mem_ready;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= ST_RUN;
      else      state_reg <= state_next;
   end

   // Priority mux and next state; a pending branch/hazard/halt stays in the
   // frozen registers and is acted on in the release cycle.
   always_comb begin
      state_next = state_reg;
      pc_load    = 1'b1;
      ifid_load  = 1'b1;
      idex_load  = 1'b1;
      exmem_load = 1'b1;
      memwb_load = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      halted     = 1'b0;
      case (state_reg)
         ST_RUN, ST_MEM_WAIT: begin
            if (mem_stall) begin
               pc_load    = 1'b0;
               ifid_load  = 1'b0;
               idex_load  = 1'b0;
               exmem_load = 1'b0;
               memwb_load = 1'b0;
               state_next = ST_MEM_WAIT;
            end else begin
               state_next = wb_halt ? ST_HALT : ST_RUN;
               if (ex_branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (load_use) begin
                  pc_load    = 1'b0;
                  ifid_load  = 1'b0;
                  idex_flush = 1'b1;
               end
            end
         end
         ST_HALT: begin
            pc_load    = 1'b0;
            ifid_load  = 1'b0;
            idex_load  = 1'b0;
            exmem_load = 1'b0;
            memwb_load = 1'b0;
            halted     = 1'b1;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   // Saturating count of non-halted cycles in which the PC did not advance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if ((state_reg != ST_HALT) && !pc_load && (cnt_reg != {CNT_W{1'b1}})) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a second instance with a 4-bit counter
// checks saturation.
module tb_pipeline_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_rs1_used, id_rs2_used, ex_mem_read;
   logic       ex_branch_taken, mem_req, mem_ready, wb_halt;

   logic       pc_load, ifid_load, idex_load, exmem_load, memwb_load;
   logic       ifid_flush, idex_flush, halted;
   logic [15:0] stall_cnt;

   logic       s_pc_load, s_ifid_load, s_idex_load, s_exmem_load, s_memwb_load;
   logic       s_ifid_flush, s_idex_flush, s_halted;
   logic [3:0] s_stall_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .wb_halt(wb_halt),
      .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
      .exmem_load(exmem_load), .memwb_load(memwb_load),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .halted(halted), .stall_cnt(stall_cnt)
   );

   pipeline_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .wb_halt(wb_halt),
      .pc_load(s_pc_load), .ifid_load(s_ifid_load), .idex_load(s_idex_load),
      .exmem_load(s_exmem_load), .memwb_load(s_memwb_load),
      .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
      .halted(s_halted), .stall_cnt(s_stall_cnt)
   );

   wire [4:0] loads   = {pc_load, ifid_load, idex_load, exmem_load, memwb_load};
   wire [1:0] flushes = {ifid_flush, idex_flush};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; wb_halt = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b0;
      #1;
      chk("rst_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_loads", 32'(loads), 32'h1f);
      chk("rst_halted", 32'(halted), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("idle_loads", 32'(loads), 32'h1f);
      chk("idle_flush", 32'(flushes), 32'd0);

      // load-use via rs2
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
      #1;
      chk("lu_loads", 32'(loads), 32'h07);
      chk("lu_flush", 32'(flushes), 32'h1);
      tick();
      idle();
      #1;
      chk("lu_cnt", 32'(stall_cnt), 32'd1);

      // destination x0 is never a hazard
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_used = 1'b1;
      #1;
      chk("x0_loads", 32'(loads), 32'h1f);
      tick();
      idle();
      #1;
      chk("x0_cnt", 32'(stall_cnt), 32'd1);

      // rs1 match but not used: no hazard; then used: hazard
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b0;
      #1;
      chk("rs1_unused", 32'(loads), 32'h1f);
      id_rs1_used = 1'b1;
      #1;
      chk("rs1_used", 32'(loads), 32'h07);
      tick();
      idle();
      #1;
      chk("rs1_cnt", 32'(stall_cnt), 32'd2);

      // branch overrides load-use
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
      ex_branch_taken = 1'b1;
      #1;
      chk("br_loads", 32'(loads), 32'h1f);
      chk("br_flush", 32'(flushes), 32'h3);
      tick();
      idle();
      #1;
      chk("br_cnt", 32'(stall_cnt), 32'd2);

      // memory stall with pending branch for 3 cycles
      mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("ms_loads%0d", i), 32'(loads), 32'h00);
         chk($sformatf("ms_flush%0d", i), 32'(flushes), 32'd0);
         tick();
      end
      chk("ms_cnt", 32'(stall_cnt), 32'd5);
      mem_ready = 1'b1;
      #1;
      chk("rel_loads", 32'(loads), 32'h1f);
      chk("rel_flush", 32'(flushes), 32'h3);
      tick();
      idle();
      #1;
      chk("rel_cnt", 32'(stall_cnt), 32'd5);
      chk("rel_halted", 32'(halted), 32'd0);

      // reset taking effect mid-MEM_WAIT
      mem_req = 1'b1; mem_ready = 1'b0;
      tick();
      chk("mw_cnt", 32'(stall_cnt), 32'd6);
      #2;
      idle();
      rst = 1'b0;
      #1;
      chk("mwrst_cnt", 32'(stall_cnt), 32'd0);
      chk("mwrst_loads", 32'(loads), 32'h1f);
      tick();
      rst = 1'b1;
      tick();
      chk("mwrst_rel_loads", 32'(loads), 32'h1f);

      // saturation: hold load-use 20 cycles
      ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      idle();
      #1;
      chk("sat4_cnt", 32'(s_stall_cnt), 32'd15);
      chk("sat16_cnt", 32'(stall_cnt), 32'd20);

      // halt during freeze is ignored until release
      mem_req = 1'b1; mem_ready = 1'b0; wb_halt = 1'b1;
      tick();
      chk("hfrz_halted", 32'(halted), 32'd0);
      chk("hfrz_cnt", 32'(stall_cnt), 32'd21);
      mem_ready = 1'b1;
      #1;
      chk("hrel_loads", 32'(loads), 32'h1f);
      tick();
      idle();
      #1;
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_loads", 32'(loads), 32'h00);
      ex_branch_taken = 1'b1;
      #1;
      chk("halt_flush", 32'(flushes), 32'd0);
      tick(); tick(); tick();
      chk("halt_stay", 32'(halted), 32'd1);
      chk("halt_cnt", 32'(stall_cnt), 32'd21);
      idle();
      #2;
      rst = 1'b0;
      #1;
      chk("hrst_halted", 32'(halted), 32'd0);
      chk("hrst_cnt", 32'(stall_cnt), 32'd0);
      chk("hrst_loads", 32'(loads), 32'h1f);
      tick();
      rst = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
